// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and types for the keypad calculator.
// Holds the opcode values used by the input controller and the execution
// sequencer, the operand/result sizes, the execution sequencer state
// encoding, and small helpers for opcode decoding.
package calc_pkg;

    localparam int DIGITS  = 6;           // BCD digits per operand/result
    localparam int BIN_W   = 20;          // binary working width, 2^20 > 999999
    localparam int BCD_W   = 4 * DIGITS;  // packed BCD width
    localparam int MAX_VAL = 999999;      // largest representable magnitude
    localparam int CNT_W   = 5;           // wide enough to count BIN_W cycles

    localparam logic [3:0] OP_ADD = 4'ha;
    localparam logic [3:0] OP_SUB = 4'hb;
    localparam logic [3:0] OP_MUL = 4'hc;
    localparam logic [3:0] OP_DIV = 4'hd;
    localparam logic [3:0] OP_EQ  = 4'he;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_CONV,
        ST_DONE
    } state_e;

    // True for the four opcodes the sequencer executes.
    function automatic logic is_exec_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Index of the final EXEC cycle: add/sub finish in one cycle, mul/div
    // iterate once per bit of the working width.
    function automatic logic [CNT_W-1:0] exec_last(input logic [3:0] op);
        return ((op == OP_MUL) || (op == OP_DIV)) ? CNT_W'(BIN_W - 1) : '0;
    endfunction

endpackage

// File: rtl/calc_exec_seq_if.sv
// calc_exec_seq_if: request/result bundle between the input controller
// (master) and the execution sequencer (slave).
//   start       one-cycle request strobe
//   opcode      keypad opcode (add/sub/mul/div)
//   num_a/num_b BCD operands, most significant digit in the top nibble
//   busy        sequencer is not idle
//   done        one-cycle result-valid pulse
//   num_result  BCD magnitude of the result
//   neg, err    result sign (sub only) and error flag
interface calc_exec_seq_if;
    import calc_pkg::*;

    logic             start;
    logic [3:0]       opcode;
    logic [BCD_W-1:0] num_a;
    logic [BCD_W-1:0] num_b;
    logic             busy;
    logic             done;
    logic [BCD_W-1:0] num_result;
    logic             neg;
    logic             err;

    modport master (
        output start, opcode, num_a, num_b,
        input  busy, done, num_result, neg, err
    );

    modport slave (
        input  start, opcode, num_a, num_b,
        output busy, done, num_result, neg, err
    );

endinterface

// File: rtl/calc_bin2bcd.sv
// calc_bin2bcd: double-dabble binary to BCD converter with fixed latency.
// The start edge loads the value and performs the first shift, so the last
// of the BIN_W shifts happens BIN_W-1 edges later and done is high in the
// cycle following it, with bcd already final.
//   clk, rst_n  clock and synchronous active-low reset
//   start       one-cycle request; bin must be valid in the same cycle
//   bin         binary value to convert
//   done        one-cycle pulse, bcd valid
//   bcd         packed BCD result, held until the next conversion
module calc_bin2bcd
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [BIN_W-1:0] cur_bin;
    logic [BCD_W-1:0] cur_bcd;
    logic [BCD_W-1:0] step_bcd;

    // One add-3-then-shift step. A digit's adjusted value reaches 8 exactly
    // when the digit was 5 or more, so that comparison is the bit shifted
    // into the next digit up.
    always_comb begin
        cur_bin  = start ? bin : bin_q;
        cur_bcd  = start ? '0 : bcd_q;
        step_bcd = '0;
        step_bcd[3:0] = {cur_bcd[2:0] + ((cur_bcd[3:0] > 4'd4) ? 3'd3 : 3'd0),
                         cur_bin[BIN_W-1]};
        for (int i = 1; i < DIGITS; i++) begin
            step_bcd[i*4 +: 4] = {cur_bcd[i*4 +: 3] + ((cur_bcd[i*4 +: 4] > 4'd4) ? 3'd3 : 3'd0),
                                  (cur_bcd[(i-1)*4 +: 4] > 4'd4)};
        end

        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start) begin
            bin_d = {cur_bin[BIN_W-2:0], 1'b0};
            bcd_d = step_bcd;
            cnt_d = CNT_W'(BIN_W - 1);
        end else if (cnt_q != '0) begin
            bin_d  = {cur_bin[BIN_W-2:0], 1'b0};
            bcd_d  = step_bcd;
            cnt_d  = cnt_q - CNT_W'(1);
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/calc_exec_seq.sv
// calc_exec_seq: execution sequencer for the keypad calculator.
// Latches two BCD operands and an opcode on start, converts the operands to
// binary (LOAD), runs add/sub in one cycle or mul/div over BIN_W cycles
// (EXEC), converts the magnitude back to BCD (CONV) and pulses done (DONE).
// Latency depends only on the opcode, never on the data.
//   CLK_1K  system clock
//   RST     synchronous active-low reset; aborts any operation in flight
//   bus     request/result bundle, slave side
module calc_exec_seq
    import calc_pkg::*;
(
    input  logic            CLK_1K,
    input  logic            RST,
    calc_exec_seq_if.slave  bus
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           op_q, op_d;
    logic [BCD_W-1:0]     a_sr_q, a_sr_d, b_sr_q, b_sr_d;
    logic [BIN_W-1:0]     a_bin_q, a_bin_d, b_bin_q, b_bin_d;
    logic                 bad_q, bad_d;
    logic [2*BIN_W-1:0]   work_q, work_d;
    logic                 neg_pend_q, neg_pend_d, err_pend_q, err_pend_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 neg_q, neg_d, err_q, err_d;
    logic [BCD_W-1:0]     result_q, result_d;

    logic [2*BIN_W-1:0]   work_cur, mul_next, div_next, step_next, res_wide;
    logic [BIN_W:0]       mul_sum, div_shift, add_sum;
    logic [BIN_W-1:0]     div_diff, div_rem, sub_mag, res_mag;
    logic                 div_ge, div_zero, res_neg, res_err;
    logic [3:0]           digit_a, digit_b;
    logic                 conv_start, conv_done;
    logic [BCD_W-1:0]     conv_bcd;

    // Arithmetic datapath. The work register holds {acc, multiplier} for
    // shift-add multiply and {remainder, dividend/quotient} for restoring
    // division; on the first EXEC cycle it is seeded straight from the
    // operands so no extra cycle is spent initialising it. The result of the
    // final EXEC cycle is taken from the next-state value so the converter
    // can start on the same edge that leaves EXEC.
    always_comb begin
        work_cur  = (cnt_q == '0) ? {{BIN_W{1'b0}}, (op_q == OP_DIV) ? a_bin_q : b_bin_q}
                                  : work_q;
        mul_sum   = {1'b0, work_cur[2*BIN_W-1:BIN_W]}
                  + {1'b0, work_cur[0] ? a_bin_q : {BIN_W{1'b0}}};
        mul_next  = {mul_sum, work_cur[BIN_W-1:1]};

        div_shift = work_cur[2*BIN_W-1:BIN_W-1];
        div_ge    = (div_shift >= {1'b0, b_bin_q});
        div_diff  = div_shift[BIN_W-1:0] - b_bin_q;
        div_rem   = div_ge ? div_diff : div_shift[BIN_W-1:0];
        div_next  = {div_rem, work_cur[BIN_W-2:0], div_ge};

        step_next = (op_q == OP_DIV) ? div_next : mul_next;

        add_sum   = {1'b0, a_bin_q} + {1'b0, b_bin_q};
        sub_mag   = (a_bin_q >= b_bin_q) ? (a_bin_q - b_bin_q) : (b_bin_q - a_bin_q);

        res_wide  = {{(BIN_W-1){1'b0}}, add_sum};
        res_neg   = 1'b0;
        div_zero  = 1'b0;
        case (op_q)
            OP_SUB: begin
                res_wide = {{BIN_W{1'b0}}, sub_mag};
                res_neg  = (a_bin_q < b_bin_q);
            end
            OP_MUL: res_wide = mul_next;
            OP_DIV: begin
                res_wide = {{BIN_W{1'b0}}, div_next[BIN_W-1:0]};
                div_zero = (b_bin_q == '0);
            end
            default: ;
        endcase

        res_err = bad_q | div_zero | (res_wide > (2*BIN_W)'(MAX_VAL));
        res_mag = res_err ? '0 : res_wide[BIN_W-1:0];
    end

    // Sequencer next-state logic. Operands are consumed MS digit first from
    // shift registers; a non-BCD digit only flags the error, the conversion
    // runs on so the timing never changes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        a_bin_d    = a_bin_q;
        b_bin_d    = b_bin_q;
        bad_d      = bad_q;
        work_d     = work_q;
        neg_pend_d = neg_pend_q;
        err_pend_d = err_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        neg_d      = neg_q;
        err_d      = err_q;
        result_d   = result_q;
        conv_start = 1'b0;
        digit_a    = a_sr_q[BCD_W-1 -: 4];
        digit_b    = b_sr_q[BCD_W-1 -: 4];

        case (state_q)
            ST_IDLE: begin
                if (bus.start && is_exec_op(bus.opcode)) begin
                    a_sr_d  = bus.num_a;
                    b_sr_d  = bus.num_b;
                    op_d    = bus.opcode;
                    a_bin_d = '0;
                    b_bin_d = '0;
                    bad_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                a_bin_d = (a_bin_q << 3) + (a_bin_q << 1) + BIN_W'(digit_a);
                b_bin_d = (b_bin_q << 3) + (b_bin_q << 1) + BIN_W'(digit_b);
                bad_d   = bad_q | (digit_a > 4'd9) | (digit_b > 4'd9);
                a_sr_d  = {a_sr_q[BCD_W-5:0], 4'h0};
                b_sr_d  = {b_sr_q[BCD_W-5:0], 4'h0};
                if (cnt_q == CNT_W'(DIGITS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EXEC: begin
                work_d = step_next;
                if (cnt_q == exec_last(op_q)) begin
                    conv_start = 1'b1;
                    neg_pend_d = res_neg & ~res_err;
                    err_pend_d = res_err;
                    cnt_d      = '0;
                    state_d    = ST_CONV;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CONV: begin
                if (conv_done) begin
                    result_d = conv_bcd;
                    neg_d    = neg_pend_q;
                    err_d    = err_pend_q;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_1K) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            a_bin_q    <= '0;
            b_bin_q    <= '0;
            bad_q      <= 1'b0;
            work_q     <= '0;
            neg_pend_q <= 1'b0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            a_bin_q    <= a_bin_d;
            b_bin_q    <= b_bin_d;
            bad_q      <= bad_d;
            work_q     <= work_d;
            neg_pend_q <= neg_pend_d;
            err_pend_q <= err_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            neg_q      <= neg_d;
            err_q      <= err_d;
            result_q   <= result_d;
        end
    end

    calc_bin2bcd u_bin2bcd (
        .clk   (CLK_1K),
        .rst_n (RST),
        .start (conv_start),
        .bin   (res_mag),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.num_result = result_q;
    assign bus.neg        = neg_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_calc_exec_seq.sv
// tb_calc_exec_seq: self-checking bench for calc_exec_seq. Runs a table of
// fixed operations, hand-written corner sequences (ignored start, illegal
// opcode, mid-operation reset) and random operations against an integer
// reference model of the calculator.
module tb_calc_exec_seq;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    calc_exec_seq_if bus ();

    calc_exec_seq dut (
        .CLK_1K (clk),
        .RST    (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [3:0]  op;
        logic [23:0] exp_res;
        logic        exp_neg;
        logic        exp_err;
        bit          chk_res;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    int tests_run    = 0;
    int tests_failed = 0;

    // Compare one observed value against its expectation.
    task automatic checkOutput(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    function automatic longint bcdToInt(input logic [23:0] v);
        longint r = 0;
        for (int i = 5; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [23:0] intToBcd(input longint v);
        logic [23:0] r = '0;
        longint t = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Calculator behaviour from the arithmetic rules alone.
    task automatic referenceModel(input logic [23:0] a, input logic [23:0] b, input logic [3:0] op,
                                  output logic [23:0] res, output logic n, output logic e);
        longint av = bcdToInt(a);
        longint bv = bcdToInt(b);
        longint r  = 0;
        n = 1'b0;
        e = 1'b0;
        case (op)
            OP_ADD: r = av + bv;
            OP_SUB: begin
                r = (av >= bv) ? av - bv : bv - av;
                n = (av < bv);
            end
            OP_MUL: r = av * bv;
            OP_DIV: if (bv == 0) e = 1'b1; else r = av / bv;
            default: ;
        endcase
        if (r > 999999) e = 1'b1;
        if (e) begin
            r = 0;
            n = 1'b0;
        end
        res = intToBcd(r);
    endtask

    // Issue one request sampled at edge 0, then watch the outputs at each
    // falling edge after edge k. Optionally pulse start again for edge extra_k.
    task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b, input logic [3:0] op,
                                 input int extra_k, output int done_k, output int done_cnt,
                                 output int busy_fall, output logic [23:0] res,
                                 output logic n, output logic e);
        int k;
        done_k = -1; done_cnt = 0; busy_fall = -1; res = '0; n = 1'b0; e = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = op; bus.num_a = a; bus.num_b = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.opcode = 4'h0;
        bus.num_a  = 24'($urandom);
        bus.num_b  = 24'($urandom);
        k = 0;
        while (k < 80) begin
            if (bus.done) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k = k; res = bus.num_result; n = bus.neg; e = bus.err;
                end
            end
            if (!bus.busy && busy_fall < 0) busy_fall = k;
            if (busy_fall >= 0 && k >= busy_fall + 2) break;
            if (k == extra_k - 1) begin
                bus.start = 1'b1; bus.opcode = OP_ADD;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
    endtask

    task automatic runVector(input string name, input vec_t v, input int extra_k);
        int done_k, done_cnt, busy_fall, e_cyc;
        logic [23:0] res;
        logic n, e;
        e_cyc = (v.op == OP_MUL || v.op == OP_DIV) ? 20 : 1;
        applyStimulus(v.a, v.b, v.op, extra_k, done_k, done_cnt, busy_fall, res, n, e);
        checkOutput({name, " done edge"}, done_k, 26 + e_cyc);
        checkOutput({name, " done pulses"}, done_cnt, 1);
        checkOutput({name, " busy fall"}, busy_fall, 27 + e_cyc);
        checkOutput({name, " err"}, int'(e), int'(v.exp_err));
        if (v.chk_res) begin
            checkOutput({name, " result"}, int'(res), int'(v.exp_res));
            checkOutput({name, " neg"}, int'(n), int'(v.exp_neg));
        end
    endtask

    initial begin
        int done_k, done_cnt, busy_fall, dones;
        logic [23:0] res;
        logic n, e;
        vec_t r;

        bus.start = 1'b0; bus.opcode = 4'h0; bus.num_a = '0; bus.num_b = '0;
        rst_n = 1'b0;

        vecs[0] = '{24'h000123, 24'h000456, OP_ADD, 24'h000579, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{24'h000005, 24'h000009, OP_SUB, 24'h000004, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{24'h000999, 24'h001001, OP_MUL, 24'h999999, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{24'h001000, 24'h001000, OP_MUL, 24'h000000, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{24'h000100, 24'h000007, OP_DIV, 24'h000014, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{24'h000100, 24'h000000, OP_DIV, 24'h000000, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{24'h999999, 24'h000001, OP_ADD, 24'h000000, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{24'h999999, 24'h999999, OP_SUB, 24'h000000, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{24'h00000A, 24'h000000, OP_ADD, 24'h000000, 1'b0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        checkOutput("reset busy", int'(bus.busy), 0);
        checkOutput("reset done", int'(bus.done), 0);
        checkOutput("reset result", int'(bus.num_result), 0);
        checkOutput("reset neg", int'(bus.neg), 0);
        checkOutput("reset err", int'(bus.err), 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) runVector($sformatf("vec%0d", i), vecs[i], -1);

        // A second start during an add must be dropped, not queued.
        runVector("add with start at edge 10",
                  '{24'h000321, 24'h000100, OP_ADD, 24'h000421, 1'b0, 1'b0, 1'b1}, 10);

        // An opcode outside add..div never makes the sequencer busy.
        applyStimulus(24'h000001, 24'h000002, OP_EQ, -1, done_k, done_cnt, busy_fall, res, n, e);
        checkOutput("illegal op busy fall", busy_fall, 0);
        checkOutput("illegal op done pulses", done_cnt, 0);

        // Leave non-zero outputs behind, then reset in the middle of a mul.
        runVector("sub before reset", vecs[1], -1);
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = OP_MUL; bus.num_a = 24'h000999; bus.num_b = 24'h001001;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid reset busy", int'(bus.busy), 0);
        checkOutput("mid reset done", int'(bus.done), 0);
        checkOutput("mid reset result", int'(bus.num_result), 0);
        checkOutput("mid reset neg", int'(bus.neg), 0);
        checkOutput("mid reset err", int'(bus.err), 0);
        rst_n = 1'b1;
        dones = 0;
        repeat (45) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checkOutput("aborted mul done pulses", dones, 0);
        runVector("add after reset", vecs[0], -1);

        // Random operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] op;
            longint av, bv;
            op = OP_ADD + 4'($urandom_range(0, 3));
            av = longint'($urandom_range(0, 999999));
            case (op)
                OP_MUL:  bv = longint'($urandom_range(0, 1500));
                OP_DIV:  bv = longint'($urandom_range(0, 50));
                default: bv = longint'($urandom_range(0, 999999));
            endcase
            r.a = intToBcd(av);
            r.b = intToBcd(bv);
            r.op = op;
            r.chk_res = 1'b1;
            referenceModel(r.a, r.b, r.op, r.exp_res, r.exp_neg, r.exp_err);
            runVector($sformatf("rand%0d op %0h", i, op), r, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
